cbus_arbiter: RTL and testbench

CBUS_ARBITER -- requirements
Module: cbus_arbiter

---
 rtl/cbus_arbiter_pkg.sv | 51 +++++
 rtl/cbus_arbiter.sv | 97 +++++++++
 tb/tb_cbus_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbus_arbiter_pkg.sv
// Shared bus types for the instruction/data to memory (cbus) path.
// Memory transfer size encodings live here so every bus agent agrees on them.
package cbus_arbiter_pkg;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic [63:0] data;
   } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single-beat memory bus.
// Round-robin on ties; the granted request is latched and held until ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transfer in flight; sample ireq/dreq and grant one
// ST_IBUSY | instruction fetch latched on creq, waiting for cresp.ready
// ST_DBUSY | data access latched on creq, waiting for cresp.ready
module cbus_arbiter
   import cbus_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  ibus_req_t  ireq,
   output ibus_resp_t iresp,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output cbus_req_t  creq,
   input  cbus_resp_t cresp
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_IBUSY = 2'd1,
      ST_DBUSY = 2'd2
   } state_t;

   state_t      state_q;
   logic        last_dbus_q;
   logic        is_write_q;
   logic [63:0] addr_q;
   msize_t      size_q;
   logic [7:0]  strobe_q;
   logic [63:0] data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         last_dbus_q <= 1'b0;
         is_write_q  <= 1'b0;
         addr_q      <= '0;
         size_q      <= MSIZE1;
         strobe_q    <= '0;
         data_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // ibus wins when alone, or on a tie if dbus had the last grant
               if (ireq.valid && (!dreq.valid || last_dbus_q)) begin
                  state_q     <= ST_IBUSY;
                  last_dbus_q <= 1'b0;
                  is_write_q  <= 1'b0;
                  addr_q      <= ireq.addr;
                  size_q      <= MSIZE4;
                  strobe_q    <= '0;
                  data_q      <= '0;
               end else if (dreq.valid) begin
                  state_q     <= ST_DBUSY;
                  last_dbus_q <= 1'b1;
                  is_write_q  <= (dreq.strobe != 8'h00);
                  addr_q      <= dreq.addr;
                  size_q      <= dreq.size;
                  strobe_q    <= dreq.strobe;
                  data_q      <= dreq.data;
               end
            end
            ST_IBUSY, ST_DBUSY: begin
               if (cresp.ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      creq          = '0;
      creq.valid    = (state_q != ST_IDLE);
      creq.is_write = is_write_q;
      creq.addr     = addr_q;
      creq.size     = size_q;
      creq.strobe   = strobe_q;
      creq.data     = data_q;

      iresp         = '0;
      iresp.addr_ok = (state_q == ST_IBUSY) && cresp.ready;
      iresp.data_ok = (state_q == ST_IBUSY) && cresp.ready;
      iresp.data    = addr_q[2] ? cresp.data[63:32] : cresp.data[31:0];

      dresp         = '0;
      dresp.addr_ok = (state_q == ST_DBUSY) && cresp.ready;
      dresp.data_ok = (state_q == ST_DBUSY) && cresp.ready;
      dresp.data    = cresp.data;
   end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin model.
module tb_cbus_arbiter;
   import cbus_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   ibus_req_t  ireq;
   ibus_resp_t iresp;
   dbus_req_t  dreq;
   dbus_resp_t dresp;
   cbus_req_t  creq;
   cbus_resp_t cresp;

   int checks   = 0;
   int failures = 0;
   bit model_last_d = 1'b0;

   cbus_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .ireq  (ireq),
      .iresp (iresp),
      .dreq  (dreq),
      .dresp (dresp),
      .creq  (creq),
      .cresp (cresp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic cbus_req_t exp_from_i(input ibus_req_t r);
      cbus_req_t e;
      e = '0;
      e.valid = 1'b1;
      e.addr  = r.addr;
      e.size  = MSIZE4;
      return e;
   endfunction

   function automatic cbus_req_t exp_from_d(input dbus_req_t r);
      cbus_req_t e;
      e = '0;
      e.valid    = 1'b1;
      e.is_write = (r.strobe != 8'h00);
      e.addr     = r.addr;
      e.size     = r.size;
      e.strobe   = r.strobe;
      e.data     = r.data;
      return e;
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      ireq  = '{valid: 1'b1, addr: 64'h1234};
      dreq  = '0;
      cresp = '{ready: 1'b1, data: 64'hFFFF_FFFF_FFFF_FFFF};
      #1;
      checks++;
      if (creq !== cbus_req_t'('0)) begin
         failures++;
         $display("FAIL reset_creq got=%h want=0", creq);
      end
      checks++;
      if ({iresp.addr_ok, iresp.data_ok, dresp.addr_ok, dresp.data_ok} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_oks got=%b want=0000",
                  {iresp.addr_ok, iresp.data_ok, dresp.addr_ok, dresp.data_ok});
      end
      tick();
      ireq  = '0;
      cresp = '0;
      reset = 1'b1;
      model_last_d = 1'b0;
      tick();
   endtask

   task automatic test_ifetch();
      cbus_req_t e;
      ireq = '{valid: 1'b1, addr: 64'h8000_0004};
      dreq = '0;
      e = exp_from_i(ireq);
      tick();
      ireq = '0;
      checks++;
      if (creq !== e) begin
         failures++;
         $display("FAIL ifetch_creq got=%h want=%h", creq, e);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (iresp.data_ok !== 1'b0 || creq !== e) begin
            failures++;
            $display("FAIL ifetch_wait data_ok=%b creq=%h want data_ok=0 creq=%h",
                     iresp.data_ok, creq, e);
         end
      end
      tick();
      cresp = '{ready: 1'b1, data: 64'h1111_2222_3333_4444};
      #1;
      checks++;
      if ({iresp.addr_ok, iresp.data_ok, iresp.data} !== {2'b11, 32'h1111_2222}) begin
         failures++;
         $display("FAIL ifetch_resp got ok=%b%b data=%h want ok=11 data=11112222",
                  iresp.addr_ok, iresp.data_ok, iresp.data);
      end
      checks++;
      if ({dresp.addr_ok, dresp.data_ok} !== 2'b00) begin
         failures++;
         $display("FAIL ifetch_dsilent got=%b%b want=00", dresp.addr_ok, dresp.data_ok);
      end
      tick();
      cresp = '0;
      #1;
      checks++;
      if (creq.valid !== 1'b0 || iresp.data_ok !== 1'b0) begin
         failures++;
         $display("FAIL ifetch_done valid=%b data_ok=%b want 0 0", creq.valid, iresp.data_ok);
      end
      model_last_d = 1'b0;
   endtask

   task automatic test_dstore();
      cbus_req_t e;
      ireq = '0;
      dreq = '{valid: 1'b1, addr: 64'h8000_1000, size: MSIZE4, strobe: 8'h0F,
               data: 64'hDEAD_BEEF};
      e = exp_from_d(dreq);
      tick();
      dreq.valid = 1'b0;
      checks++;
      if (creq !== e || creq.is_write !== 1'b1) begin
         failures++;
         $display("FAIL dstore_creq got=%h want=%h", creq, e);
      end
      cresp = '{ready: 1'b1, data: 64'hCAFE_F00D_0000_0001};
      #1;
      checks++;
      if ({dresp.addr_ok, dresp.data_ok, dresp.data} !== {2'b11, 64'hCAFE_F00D_0000_0001}
          || {iresp.addr_ok, iresp.data_ok} !== 2'b00) begin
         failures++;
         $display("FAIL dstore_resp got d=%b%b data=%h i=%b%b want d=11 i=00",
                  dresp.addr_ok, dresp.data_ok, dresp.data, iresp.addr_ok, iresp.data_ok);
      end
      tick();
      cresp = '0;
      model_last_d = 1'b1;
   endtask

   task automatic test_round_robin();
      bit exp_d;
      reset = 1'b0;
      #1;
      reset = 1'b1;
      model_last_d = 1'b0;
      ireq = '{valid: 1'b1, addr: 64'h1000};
      dreq = '{valid: 1'b1, addr: 64'h2000, size: MSIZE8, strobe: 8'h00, data: 64'h0};
      cresp = '0;
      for (int k = 0; k < 4; k++) begin
         exp_d = !model_last_d;
         tick();
         checks++;
         if (creq.addr !== (exp_d ? 64'h2000 : 64'h1000)) begin
            failures++;
            $display("FAIL rr_grant%0d got addr=%h want=%h", k, creq.addr,
                     exp_d ? 64'h2000 : 64'h1000);
         end
         tick();
         cresp = '{ready: 1'b1, data: 64'h0};
         #1;
         checks++;
         if ({iresp.data_ok, dresp.data_ok} !== {!exp_d, exp_d}) begin
            failures++;
            $display("FAIL rr_resp%0d got i=%b d=%b want i=%b d=%b", k,
                     iresp.data_ok, dresp.data_ok, !exp_d, exp_d);
         end
         tick();
         cresp = '0;
         model_last_d = exp_d;
      end
      ireq = '0;
      dreq = '0;
   endtask

   task automatic test_reset_mid();
      dreq = '{valid: 1'b1, addr: 64'h3000, size: MSIZE8, strobe: 8'hFF, data: 64'h55};
      ireq = '0;
      tick();
      ireq = '{valid: 1'b1, addr: 64'h4000};
      #1;
      checks++;
      if (creq.valid !== 1'b1 || creq.addr !== 64'h3000) begin
         failures++;
         $display("FAIL rstmid_busy valid=%b addr=%h want 1 3000", creq.valid, creq.addr);
      end
      #1;
      reset = 1'b0;
      cresp = '{ready: 1'b1, data: 64'h77};
      #1;
      checks++;
      if (creq !== cbus_req_t'('0) || dresp.data_ok !== 1'b0 || iresp.data_ok !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_abort creq=%h d_ok=%b i_ok=%b want 0", creq,
                  dresp.data_ok, iresp.data_ok);
      end
      tick();
      dreq.valid = 1'b0;
      cresp = '0;
      reset = 1'b1;
      model_last_d = 1'b0;
      tick();
      checks++;
      if (creq !== exp_from_i(ireq)) begin
         failures++;
         $display("FAIL rstmid_regrant got=%h want=%h", creq, exp_from_i(ireq));
      end
      cresp = '{ready: 1'b1, data: 64'h0};
      tick();
      cresp = '0;
      ireq = '0;
   endtask

   task automatic test_ready_stream();
      int fetches = 0;
      bit prev_ok = 1'b0;
      ireq = '{valid: 1'b1, addr: 64'h10};
      dreq = '0;
      cresp = '{ready: 1'b1, data: 64'hAAAA_BBBB_CCCC_DDDD};
      #1;
      for (int c = 0; c < 20; c++) begin
         checks++;
         if (iresp.data_ok !== c[0]) begin
            failures++;
            $display("FAIL stream_cycle%0d got=%b want=%b", c, iresp.data_ok, c[0]);
         end
         if (iresp.data_ok === 1'b1 && prev_ok) begin
            failures++;
            $display("FAIL stream_consecutive cycle=%0d got=1 want=0", c);
         end
         prev_ok = iresp.data_ok;
         if (iresp.data_ok === 1'b1) fetches++;
         tick();
      end
      checks++;
      if (fetches != 10) begin
         failures++;
         $display("FAIL stream_count got=%0d want=10", fetches);
      end
      // last sampled cycle was a response cycle, so the arbiter is back in IDLE
      ireq = '0;
      cresp = '0;
      model_last_d = 1'b0;
      tick();
   endtask

   task automatic test_random();
      ibus_req_t ri;
      dbus_req_t rd;
      cbus_req_t e;
      bit        grant_d;
      int        waits;
      logic [63:0] rdata;
      for (int t = 0; t < 60; t++) begin
         ri.valid  = ($urandom_range(0, 2) != 0);
         ri.addr   = {$urandom, $urandom};
         rd.valid  = ($urandom_range(0, 2) != 0);
         rd.addr   = {$urandom, $urandom};
         rd.size   = msize_t'($urandom_range(0, 3));
         rd.strobe = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         rd.data   = {$urandom, $urandom};
         ireq  = ri;
         dreq  = rd;
         cresp = '{ready: 1'($urandom), data: {$urandom, $urandom}};
         #1;
         checks++;
         if ({creq.valid, iresp.data_ok, iresp.addr_ok, dresp.data_ok, dresp.addr_ok} !== 5'b0) begin
            failures++;
            $display("FAIL rand_idle%0d got v=%b i=%b%b d=%b%b want 0", t, creq.valid,
                     iresp.addr_ok, iresp.data_ok, dresp.addr_ok, dresp.data_ok);
         end
         tick();
         if (!ri.valid && !rd.valid) begin
            checks++;
            if (creq.valid !== 1'b0) begin
               failures++;
               $display("FAIL rand_nogrant%0d got valid=%b want 0", t, creq.valid);
            end
            continue;
         end
         grant_d = (ri.valid && rd.valid) ? !model_last_d : rd.valid;
         e = grant_d ? exp_from_d(rd) : exp_from_i(ri);
         model_last_d = grant_d;
         cresp.ready = 1'b0;
         if ($urandom_range(0, 1) == 1) begin
            ireq.valid = 1'b0;
            dreq.valid = 1'b0;
         end
         ireq.addr = {$urandom, $urandom};
         dreq.addr = {$urandom, $urandom};
         #1;
         checks++;
         if (creq !== e) begin
            failures++;
            $display("FAIL rand_creq%0d got=%h want=%h", t, creq, e);
         end
         waits = $urandom_range(0, 2);
         for (int w = 0; w < waits; w++) begin
            tick();
            checks++;
            if (creq !== e || iresp.data_ok !== 1'b0 || dresp.data_ok !== 1'b0) begin
               failures++;
               $display("FAIL rand_hold%0d got=%h want=%h", t, creq, e);
            end
         end
         rdata = {$urandom, $urandom};
         cresp = '{ready: 1'b1, data: rdata};
         #1;
         checks++;
         if ({iresp.addr_ok, iresp.data_ok, dresp.addr_ok, dresp.data_ok}
             !== {!grant_d, !grant_d, grant_d, grant_d}) begin
            failures++;
            $display("FAIL rand_oks%0d got i=%b%b d=%b%b want grant_d=%b", t,
                     iresp.addr_ok, iresp.data_ok, dresp.addr_ok, dresp.data_ok, grant_d);
         end
         checks++;
         if (grant_d ? (dresp.data !== rdata)
                     : (iresp.data !== (e.addr[2] ? rdata[63:32] : rdata[31:0]))) begin
            failures++;
            $display("FAIL rand_data%0d got i=%h d=%h rdata=%h addr=%h", t,
                     iresp.data, dresp.data, rdata, e.addr);
         end
         tick();
         cresp = '0;
      end
      ireq = '0;
      dreq = '0;
   endtask

   initial begin
      test_reset();
      test_ifetch();
      test_dstore();
      test_round_robin();
      test_reset_mid();
      test_ready_stream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
